// File: rtl/uart_tx_fifo_if.sv
// CPU-side write port of the buffered UART transmitter.
// Carries the push strobe and character, and returns the FIFO status flags.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic                 wr_en;
  logic [DATA_BITS-1:0] wr_data;
  logic                 full;
  logic                 empty;
  logic [LEVEL_W-1:0]   level;
  logic                 overflow;

  modport master (
    output wr_en,
    output wr_data,
    input  full,
    input  empty,
    input  level,
    input  overflow
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output full,
    output empty,
    output level,
    output overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: character FIFO feeding a tick-paced frame engine
// (start, LSB-first data, optional parity, one or two stop bits).
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic [1:0]    parity_mode,
  input  logic          two_stop,
  uart_tx_fifo_if.slave wr_if,
  output logic          busy,
  output logic          tx_done,
  output logic          txd
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W = PTR_W + 1;
  localparam int CNT_W   = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic [LEVEL_W-1:0] DEPTH_L  = LEVEL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [LEVEL_W-1:0]   level_r;
  logic [LEVEL_W-1:0]   level_nxt;
  logic                 full_r;
  logic                 empty_r;
  logic                 overflow_r;
  logic                 push_s;
  logic                 pop_s;
  logic [DATA_BITS-1:0] head_s;

  state_t               state_r;
  state_t               state_nxt;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_nxt;
  logic [CNT_W-1:0]     bit_cnt_r;
  logic [CNT_W-1:0]     bit_cnt_nxt;
  logic                 stop_cnt_r;
  logic                 stop_cnt_nxt;
  logic                 par_en_r;
  logic                 par_en_nxt;
  logic                 par_bit_r;
  logic                 par_bit_nxt;
  logic                 two_r;
  logic                 two_nxt;
  logic                 txd_r;
  logic                 txd_nxt;
  logic                 done_r;
  logic                 done_nxt;
  logic                 busy_r;

  // A push is judged against the registered full flag, so a same-cycle pop never rescues it.
  assign push_s = wr_if.wr_en & ~full_r;
  assign head_s = mem[rd_ptr_r];

  assign wr_if.full     = full_r;
  assign wr_if.empty    = empty_r;
  assign wr_if.level    = level_r;
  assign wr_if.overflow = overflow_r;
  assign txd            = txd_r;
  assign busy           = busy_r;
  assign tx_done        = done_r;

  always_comb begin
    case ({push_s, pop_s})
      2'b10:   level_nxt = level_r + LEVEL_W'(1);
      2'b01:   level_nxt = level_r - LEVEL_W'(1);
      default: level_nxt = level_r;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_s) begin
      mem[wr_ptr_r] <= wr_if.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= PTR_W'(0);
      rd_ptr_r   <= PTR_W'(0);
      level_r    <= LEVEL_W'(0);
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      level_r <= level_nxt;
      full_r  <= (level_nxt == DEPTH_L);
      empty_r <= (level_nxt == LEVEL_W'(0));
      if (wr_if.wr_en && full_r) begin
        overflow_r <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state_r;
    shift_nxt    = shift_r;
    bit_cnt_nxt  = bit_cnt_r;
    stop_cnt_nxt = stop_cnt_r;
    par_en_nxt   = par_en_r;
    par_bit_nxt  = par_bit_r;
    two_nxt      = two_r;
    txd_nxt      = txd_r;
    done_nxt     = 1'b0;
    pop_s        = 1'b0;
    if (tick) begin
      case (state_r)
        IDLE: begin
          if (!empty_r) begin
            pop_s = 1'b1;
          end else begin
            txd_nxt = 1'b1;
          end
        end
        START: begin
          txd_nxt     = shift_r[0];
          bit_cnt_nxt = CNT_W'(0);
          state_nxt   = DATA;
        end
        DATA: begin
          if (bit_cnt_r != LAST_BIT) begin
            shift_nxt   = shift_r >> 1;
            txd_nxt     = shift_r[1];
            bit_cnt_nxt = bit_cnt_r + CNT_W'(1);
          end else if (par_en_r) begin
            txd_nxt   = par_bit_r;
            state_nxt = PARITY;
          end else begin
            txd_nxt      = 1'b1;
            stop_cnt_nxt = 1'b0;
            state_nxt    = STOP;
          end
        end
        PARITY: begin
          txd_nxt      = 1'b1;
          stop_cnt_nxt = 1'b0;
          state_nxt    = STOP;
        end
        STOP: begin
          if (two_r && !stop_cnt_r) begin
            stop_cnt_nxt = 1'b1;
            txd_nxt      = 1'b1;
          end else begin
            done_nxt = 1'b1;
            // Back-to-back: the next start bit replaces the idle level on this same tick.
            if (!empty_r) begin
              pop_s = 1'b1;
            end else begin
              txd_nxt   = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
        default: begin
          txd_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      endcase
      if (pop_s) begin
        shift_nxt   = head_s;
        par_en_nxt  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
        par_bit_nxt = parity_bit(head_s, parity_mode == 2'b10);
        two_nxt     = two_stop;
        txd_nxt     = 1'b0;
        state_nxt   = START;
      end else begin
        two_nxt = two_r;
      end
    end else begin
      state_nxt = state_r;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r    <= {DATA_BITS{1'b0}};
      bit_cnt_r  <= CNT_W'(0);
      stop_cnt_r <= 1'b0;
      par_en_r   <= 1'b0;
      par_bit_r  <= 1'b0;
      two_r      <= 1'b0;
      txd_r      <= 1'b1;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      shift_r    <= shift_nxt;
      bit_cnt_r  <= bit_cnt_nxt;
      stop_cnt_r <= stop_cnt_nxt;
      par_en_r   <= par_en_nxt;
      par_bit_r  <= par_bit_nxt;
      two_r      <= two_nxt;
      txd_r      <= txd_nxt;
      done_r     <= done_nxt;
      busy_r     <= (state_nxt != IDLE);
    end
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised buffered UART transmitter for the mini computer's serial port. The CPU side pushes characters into an internal FIFO. A frame engine serialises them LSB-first with configurable parity and stop-bit count, paced by an external bit-rate tick from the baud generator. Consecutive characters go out back-to-back with no idle gap while the FIFO holds data.

## Interface
- DATA_BITS, 8, character width; legal 5..8
- FIFO_DEPTH, 8, FIFO entries; power of two, 2..64
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- tick  in  1  one-clk pulse per bit period; all line changes are aligned to it
- wr_en  in  1  push wr_data into FIFO
- wr_data  in  DATA_BITS  character to send
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 none
- two_stop  in  1  1 = two stop bits, 0 = one
- full  out  1  FIFO holds FIFO_DEPTH entries
- empty  out  1  FIFO holds 0 entries
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky; set when wr_en is asserted while full
- busy  out  1  frame engine not in IDLE
- tx_done  out  1  one-clk pulse at the end of each frame
- txd  out  1  serial line, registered, idle high

## Operation
- Reset values: txd=1, busy=0, tx_done=0, overflow=0, level=0, empty=1, full=0, FIFO pointers 0, state IDLE.
- Reset mid-frame aborts the frame. txd returns to 1 immediately and the FIFO contents are discarded.
- FIFO write:
  - wr_en with full=0 stores wr_data at the write pointer and increments level.
  - wr_en with full=1 is dropped, sets overflow, and leaves the FIFO unchanged. This holds even if a pop occurs in the same cycle.
- Pointers are $clog2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH.
- Simultaneous accepted push and pop leaves level unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP. All transitions below happen only on cycles with tick=1.
  - IDLE:
    - tick=1 and empty=0: pop the head entry into the shift register and latch parity_mode and two_stop for the whole frame.
    - Compute the parity bit: even = XOR of data bits, odd = its inverse.
    - Drive txd=0 and go to START.
  - START: on tick, drive data bit 0, clear the bit counter, go to DATA.
  - DATA:
    - On tick with bit counter < DATA_BITS-1: shift, drive the next bit, increment the counter.
    - On tick with counter = DATA_BITS-1: go to PARITY if parity is enabled (drive the parity bit). Otherwise go to STOP (drive 1).
  - PARITY: on tick, drive 1, go to STOP, set the stop counter to 0.
  - STOP:
    - On tick with two_stop latched and stop counter = 0: increment the counter and keep txd=1.
    - On the final stop tick: pulse tx_done. If empty=0, pop the next entry and drive the start bit in that same cycle (back-to-back, go to START). Otherwise go to IDLE with txd=1.
- busy=1 in every state except IDLE.
- Changing parity_mode or two_stop mid-frame has no effect until the next frame load.

## Timing
- Every line bit lasts exactly one tick period. The first start bit begins at the first tick after data becomes available.
- Frame length in ticks: 1 + DATA_BITS + (parity?1:0) + (two_stop?2:1).
- txd, busy and tx_done update on the clk edge at which tick=1 is sampled. txd is registered and has no combinational path from inputs.
- Push-to-flags latency: wr_en at edge N gives level, empty and full updated after edge N.
- The pop at a frame load updates level after the same edge.
- tick asserted continuously (every clk) is legal and yields one bit per clk.
- tick held low freezes the FSM and txd. FIFO writes continue to be accepted.

## Test plan
- Even parity, one stop: DATA_BITS=8, parity_mode=01, two_stop=0, tick every 4 clk, write 0xA5 -> txd bit sequence 0,1,0,1,0,0,1,0,1,0,1. One tx_done pulse. busy low after the last tick, empty=1.
- Odd parity, two stops: write 0x03 with parity_mode=10, two_stop=1 -> 0,1,1,0,0,0,0,0,0,1,1,1 (12 tick periods).
- Back-to-back: write 0x55, 0x0F, 0xFF in consecutive clks with parity none -> three 10-bit frames with no idle bit between them. Three tx_done pulses. level goes 1,2,3 and then decrements at each frame load.
- Overflow: FIFO_DEPTH=4, tick=0, write 5 bytes -> full=1 after the 4th write, 5th byte dropped, overflow=1 and sticky. Enable tick -> exactly 4 frames sent.
- Reset mid-frame: assert rst during DATA of 0x81 with 2 entries queued -> txd=1, busy=0, level=0, overflow=0 immediately. No tx_done pulse.
- Width and continuous tick: DATA_BITS=5, tick tied high, write 0x1B, parity none -> 0,1,1,0,1,1,1 on consecutive clks.
